// File: rtl/spi_slave_rx.sv
// spi_slave_rx: receive endpoint of the 3-wire SPI link.
// Synchronizes sclk/cs/mosi onto clk, takes one LSB-first word per
// chip-select frame (after a discarded lead-in slot) and reports it.
// Ports:
//   clk, rst        system clock, async active-high reset
//   sclk, cs, mosi  raw SPI pins (cs active low)
//   dout            last completed word, held until the next one
//   done            1-cycle strobe, dout is new
//   frame_err       1-cycle strobe, frame aborted short
//   busy            frame in progress (LEAD or SHIFT)
module spi_slave_rx #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        HOLD
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] primed;
    logic                   sclk_dly;
    logic                   cs_dly;

    logic sclk_cur, cs_cur, mosi_cur;
    logic sclk_fall, cs_fall, cs_rise;
    logic cs_seen_high;

    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic [WIDTH-1:0] dout_n;
    logic             done_n, err_n;
    logic             last_bit;

    // Input synchronizers plus edge-detect delay flops.
    // primed marks when the cs chain holds real pin samples rather
    // than its reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            primed    <= '0;
            sclk_dly  <= 1'b0;
            cs_dly    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            primed    <= {primed[SYNC_STAGES-2:0], 1'b1};
            sclk_dly  <= sclk_cur;
            cs_dly    <= cs_cur;
        end
    end

    assign sclk_cur  = sclk_sync[SYNC_STAGES-1];
    assign cs_cur    = cs_sync[SYNC_STAGES-1];
    assign mosi_cur  = mosi_sync[SYNC_STAGES-1];
    assign sclk_fall = sclk_dly & ~sclk_cur;
    assign cs_fall   = cs_dly & ~cs_cur;
    assign cs_rise   = ~cs_dly & cs_cur;
    assign last_bit  = (count == CW'(WIDTH - 1));

    // cs must be seen high on the pin before a fall counts as a frame
    // start; the reset value of the synchronizer does not qualify.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_seen_high <= 1'b0;
        end else if (primed[SYNC_STAGES-1] && cs_cur) begin
            cs_seen_high <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; cs_rise always has priority over sclk_fall.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (cs_fall && cs_seen_high) begin
                    state_n = LEAD;
                end
            end
            LEAD: begin
                if (cs_rise) begin
                    state_n = IDLE;
                end else if (sclk_fall) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_n = IDLE;
                end else if (sclk_fall && last_bit) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        busy    = (state == LEAD) || (state == SHIFT);
        count_n = count;
        shift_n = shift;
        dout_n  = dout;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                count_n = '0;
                shift_n = '0;
            end
            LEAD: begin
                if (cs_rise) begin
                    err_n = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    err_n = 1'b1;
                end else if (sclk_fall) begin
                    shift_n[count] = mosi_cur;
                    count_n        = count + CW'(1);
                    if (last_bit) begin
                        dout_n  = shift_n;
                        done_n  = 1'b1;
                        count_n = '0;
                    end
                end
            end
            HOLD: begin
                count_n = '0;
            end
            default: begin
                count_n = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            shift     <= '0;
            dout      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            count     <= count_n;
            shift     <= shift_n;
            dout      <= dout_n;
            done      <= done_n;
            frame_err <= err_n;
        end
    end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Receive-side endpoint of the team's 3-wire SPI link (sclk, cs, mosi). Runs on the system clock, oversamples the incoming SPI pins through synchronizers, deserializes one LSB-first word per chip-select frame and presents it as a parallel word with a one-cycle `done` strobe. It sits opposite `spi_master` on the same board-level link and feeds the downstream register or command logic.

## Interface
- `WIDTH`, 12, data bits per frame.
- `SYNC_STAGES`, 2, flip-flop stages on each SPI input (≥2).
- `clk`  input  1  system clock; all logic on posedge.
- `rst`  input  1  reset, asynchronous, active-high.
- `sclk`  input  1  SPI serial clock from the master, asynchronous to `clk`.
- `cs`  input  1  chip select, active low, asynchronous.
- `mosi`  input  1  serial data; master changes it on sclk rising edges.
- `dout`  output  WIDTH  last completed word, held until the next completion.
- `done`  output  1  one-cycle strobe; `dout` is valid and new.
- `frame_err`  output  1  one-cycle strobe; frame aborted short.
- `busy`  output  1  high while a frame is in progress (LEAD or SHIFT).

## Operation
- Synchronizers: `sclk`, `cs` and `mosi` each pass through SYNC_STAGES flops plus one delay flop for edge detect. Synchronizer reset values: sclk 0, cs 1, mosi 0.
- Edge events are computed from the synchronized signals:
  - sclk_fall = delayed & ~current.
  - cs_fall and cs_rise are formed the same way.
- Sampling is on sclk falling edges, the middle of each bit.
- Bit order is LSB first: data bit k goes to shift[k].
- The bit counter is ceil(log2(WIDTH+1)) wide and counts 0..WIDTH-1.
- States:
  - IDLE: waits for cs_fall, then goes to LEAD. Counter and shift register are cleared.
  - LEAD: the first sclk_fall after cs falls is a lead-in slot. Its data is discarded; go to SHIFT.
  - SHIFT: each sclk_fall writes the synchronized mosi into shift[count] and increments count. On the WIDTH-th bit:
    - `dout` gets the full word, including this bit.
    - `done` pulses.
    - Go to HOLD.
  - HOLD: extra sclk edges are ignored. cs_rise goes to IDLE with no error.
- Abort: cs_rise in LEAD or SHIFT:
  - `frame_err` pulses for one cycle.
  - `dout` is unchanged.
  - Go to IDLE.
- Simultaneous cs_rise and sclk_fall in the same cycle: cs_rise wins. The bit is not taken.
  - In SHIFT with count = WIDTH-1 this is an abort, not a completion.
- cs_fall while in LEAD, SHIFT or HOLD cannot occur without a prior cs_rise, so no special handling is needed.
- Reset mid-frame: everything clears and the FSM enters IDLE.
  - A new frame needs a real cs high→low transition.
  - If cs is already low when reset releases, it is not a frame start, because the synchronizer resets to 1 and produces a cs_fall. To avoid this, cs_fall in IDLE is qualified by a `cs_seen_high` flag that is cleared by reset and set when synchronized cs = 1.

## Timing
- Reset values:
  - `dout` = 0, `done` = 0, `frame_err` = 0, `busy` = 0.
  - State = IDLE, count = 0, shift = 0, `cs_seen_high` = 0.
- Latency:
  - From a pin transition to edge detection: SYNC_STAGES+1 clk edges, with +1 uncertainty from the asynchronous sampling.
  - `done`/`dout` are registered on the detection edge, so they are visible SYNC_STAGES+1..SYNC_STAGES+2 cycles after the final sclk fall.
- `done` and `frame_err` are single-cycle and are never high together.
- `busy` rises the cycle after cs_fall is detected. It falls the cycle after completion (`done`) or after abort.
- Input constraints:
  - sclk high and low phases are ≥ SYNC_STAGES+2 clk cycles each.
  - mosi is stable ≥ SYNC_STAGES+2 cycles around each sclk fall.
  - The system master (half-period 11 clk) satisfies both.
- Frame spacing: cs high for at least 1 sclk period between frames.

## Test plan
- Single frame: cs low, lead-in, then WIDTH bits of 0xA5C LSB first at half-period 11 → one `done` pulse, `dout` = 0xA5C, `frame_err` = 0, `busy` low after.
- Back-to-back frames 0x001 then 0x800 → two `done` pulses; `dout` = 0x001 then 0x800; boundary bits land in the correct positions.
- Short frame: cs rises after 5 data bits → `frame_err` pulse, no `done`, `dout` keeps its previous value, state returns to IDLE.
- Over-long frame: 15 sclk falls with cs low → one `done` after bit 12, `dout` correct, no error on cs rise.
- Reset mid-frame after 6 bits, with cs held low through reset release → all outputs 0. Nothing is received until cs goes high then low; the next full frame with 0x3C3 gives `done` and `dout` = 0x3C3.
- cs rise coincident with the 12th sclk fall, both arriving at the pins in the same clk cycle → `frame_err`, no `done`.
